// File: rtl/wb_demux_2_32b_pkg.sv
// Shared processor constants: default result/destination widths and the hard-wired zero register.
package wb_demux_2_32b_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEST_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;
    localparam logic [7:0]  DROP_MAX   = 8'hFF;

endpackage

// File: rtl/wb_demux_2_32b_demux_slot.sv
// One-entry holding slot for a demux output port; load wins over drain so fill+drain never bubbles.
// Latency 1 from load to valid; backpressure is handled by the parent via valid/ready.
module demux_slot
    import wb_demux_2_32b_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DEST_W-1:0] load_dest,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [DEST_W-1:0] dest
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            dest  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            dest  <= load_dest;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_demux_2_32b.sv
// Routes a writeback result to one of two held output ports; writes to $0 on port 0 are dropped and counted.
// Latency 1; in_ready reflects only the selected slot, which frees up in the same cycle it is drained.
module wb_demux_2_32b
    import wb_demux_2_32b_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic [DEST_W-1:0] out0_dest,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [DEST_W-1:0] out1_dest,
    output logic [7:0]        drop_cnt
);

    logic accept;
    logic drop_zero;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    assign in_ready  = in_sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
    assign accept    = in_valid && in_ready;
    // $0 only exists on the register-file side (port 0); port 1 forwards it untouched.
    assign drop_zero = accept && !in_sel && (in_dest == DEST_W'(REG_ZERO));
    assign load0     = accept && !in_sel && !drop_zero;
    assign load1     = accept && in_sel;
    assign drain0    = out0_valid && out0_ready;
    assign drain1    = out1_valid && out1_ready;

    demux_slot #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_slot0 (
        .clock     (clock),
        .reset     (reset),
        .load      (load0),
        .drain     (drain0),
        .load_data (in_data),
        .load_dest (in_dest),
        .valid     (out0_valid),
        .data      (out0_data),
        .dest      (out0_dest)
    );

    demux_slot #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_slot1 (
        .clock     (clock),
        .reset     (reset),
        .load      (load1),
        .drain     (drain1),
        .load_data (in_data),
        .load_dest (in_dest),
        .valid     (out1_valid),
        .data      (out1_data),
        .dest      (out1_dest)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_zero && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
